ps2_zx_keyboard: RTL and testbench
==================================

// Module: ps2_zx_keyboard
// PURPOSE
//  PS/2 keyboard receiver feeding the ZX Spectrum keyboard port (#FE read path).
//  Deserialises PS/2 set-2 frames, tracks make/break of mapped keys, and presents
//  the 8x5 Spectrum matrix as the active-low D[4:0] for the address-high byte on
//  the bus. Sits upstream of the CPU data-bus mux that now returns 8'hFF for I/O reads.
// PARAMETERS
//  TIMEOUT   2500   clk cycles without a PS/2 falling edge mid-frame before abort (100us @25MHz)
// PORTS
//  clk       in   1  system clock (25 MHz domain)
//  rst       in   1  asynchronous, active-high reset
//  ps2_clk   in   1  raw PS/2 clock line (asynchronous, device-driven)
//  ps2_dat   in   1  raw PS/2 data line (asynchronous)
//  port_hi   in   8  CPU A[15:8] during IN from #FE; bit i=0 selects matrix row i
//  kbd_data  out  5  active-low column bits for bus D[4:0]
//  scancode  out  8  last valid received byte
//  strobe    out  1  1-cycle pulse when scancode updates
//  err       out  1  1-cycle pulse on framing/parity error or timeout
// BEHAVIOUR
//  Clocking/reset: one clock and one asynchronous active-high reset, named clk and rst.
//  - rst: kbd_data=5'b11111, scancode=0, strobe=0, err=0, all key flags clear, prefixes
//    clear, FSM=IDLE, synchronisers=1. Reset mid-frame discards the partial frame.
//  - ps2_clk/ps2_dat pass 2-FF synchronisers; a bit is sampled on the cycle a synced
//    ps2_clk 1->0 edge is detected. Lines are input-only (no host-to-device).
//  - Frame FSM: IDLE -> (edge, dat=0) DATA; (edge, dat=1) stays IDLE, err pulse.
//    DATA: 8 bits LSB first, 3-bit counter -> PARITY; PARITY: store bit -> STOP.
//    STOP: dat=1 and odd parity over data+parity -> byte valid; else err. -> IDLE.
//  - Timeout: counter cleared on every edge and in IDLE; reaching TIMEOUT in any
//    non-IDLE state -> IDLE, err pulse, prefixes cleared.
//  - Byte valid: scancode<=byte, strobe=1 next cycle (latency 1 clk after STOP edge).
//  - Decoder: E0 sets ext flag; F0 sets brk flag; any other byte is looked up with ext,
//    sets (make) or clears (break) that key's flag, then ext and brk both clear.
//    Unmapped codes (AA, FA, EE, E1, ...) change no flag, still clear prefixes.
//    Error/timeout clears prefixes but not key flags.
//  - Key map (one flag per PS/2 key; matrix bit = OR of all flags mapping to it):
//    row0 A8:  CS Z X C V     row1 A9:  A S D F G     row2 A10: Q W E R T
//    row3 A11: 1 2 3 4 5      row4 A12: 0 9 8 7 6     row5 A13: P O I U Y
//    row6 A14: ENT L K J H    row7 A15: SP SS M N B   (bit0 = first listed)
//    LShift 12/RShift 59 -> CS; LCtrl 14/RCtrl E0 14 -> SS; Enter 5A; Space 29;
//    Backspace 66 -> CS+0; E0 6B left -> CS+5; E0 72 down -> CS+6; E0 75 up -> CS+7;
//    E0 74 right -> CS+8. Letters/digits use standard set-2 codes (A=1C, Z=1A, 1=16).
//  - kbd_data registered each clk: bit j = ~OR over rows i with port_hi[i]=0 of
//    matrix[i][j]; port_hi=FF -> 5'b11111. Latency 1 clk from port_hi or flag change.
//  - Simultaneous key-flag update and port_hi change: output reflects both next cycle.
// TESTING
//  1 Frame 1C (start0, 0011 1000 LSB-first, par0, stop1), port_hi=FD -> kbd_data=5'b11110,
//    scancode=1C, one strobe; then F0 1C -> kbd_data=5'b11111, flag clear.
//  2 Press 12 and 1A, port_hi=FE -> 5'b11100; port_hi=00 -> 5'b11100; port_hi=FF -> 5'b11111.
//  3 E0 6B, port_hi=FE -> 5'b11110, port_hi=F7 -> 5'b01111; then 12 make/break -> CS
//    stays set while left held; E0 F0 6B -> all 5'b11111.
//  4 Frame 1C with parity=1 -> err pulse, no strobe, kbd_data unchanged; bad stop bit same.
//  5 Stop ps2_clk after 4 data bits for >2500 clk -> err pulse, FSM IDLE; next good
//    frame 15 -> port_hi=FB gives 5'b11110.
//  6 Assert rst mid-frame with key 29 held -> all outputs reset values, port_hi=7F -> 11111.

Source files
------------

// File: rtl/ps2_zx_keyboard_if.sv
// Bus bundle for the PS/2-to-ZX keyboard block: raw PS/2 lines, the #FE row select
// and the column/scancode results returned to the CPU side.
interface ps2_zx_keyboard_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] port_hi;
  logic [4:0] kbd_data;
  logic [7:0] scancode;
  logic       strobe;
  logic       err;

  modport master (
    output ps2_clk, ps2_dat, port_hi,
    input  kbd_data, scancode, strobe, err
  );

  modport slave (
    input  ps2_clk, ps2_dat, port_hi,
    output kbd_data, scancode, strobe, err
  );
endinterface

// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 receiver that tracks make/break of mapped keys and presents the
// ZX Spectrum 8x5 matrix as active-low columns for the selected address rows.
module ps2_zx_keyboard #(
  parameter int TIMEOUT = 2500
) (
  input logic             clk,
  input logic             rst,
  ps2_zx_keyboard_if.slave bus
);

  localparam int         TO_W   = $clog2(TIMEOUT + 1);
  localparam int         KEYS   = 47;
  localparam logic [5:0] NO_KEY = 6'h3F;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Keys 0..39 sit at matrix position row*5+col; 40..46 are extra keys folded onto
  // CS/SS and the digit row (RShift, RCtrl, Backspace, Left, Down, Up, Right).
  function automatic logic [5:0] key_lookup(input logic ext, input logic [7:0] code);
    case ({ext, code})
      9'h012: return 6'd0;   9'h01A: return 6'd1;   9'h022: return 6'd2;
      9'h021: return 6'd3;   9'h02A: return 6'd4;   9'h01C: return 6'd5;
      9'h01B: return 6'd6;   9'h023: return 6'd7;   9'h02B: return 6'd8;
      9'h034: return 6'd9;   9'h015: return 6'd10;  9'h01D: return 6'd11;
      9'h024: return 6'd12;  9'h02D: return 6'd13;  9'h02C: return 6'd14;
      9'h016: return 6'd15;  9'h01E: return 6'd16;  9'h026: return 6'd17;
      9'h025: return 6'd18;  9'h02E: return 6'd19;  9'h045: return 6'd20;
      9'h046: return 6'd21;  9'h03E: return 6'd22;  9'h03D: return 6'd23;
      9'h036: return 6'd24;  9'h04D: return 6'd25;  9'h044: return 6'd26;
      9'h043: return 6'd27;  9'h03C: return 6'd28;  9'h035: return 6'd29;
      9'h05A: return 6'd30;  9'h04B: return 6'd31;  9'h042: return 6'd32;
      9'h03B: return 6'd33;  9'h033: return 6'd34;  9'h029: return 6'd35;
      9'h014: return 6'd36;  9'h03A: return 6'd37;  9'h031: return 6'd38;
      9'h032: return 6'd39;  9'h059: return 6'd40;  9'h114: return 6'd41;
      9'h066: return 6'd42;  9'h16B: return 6'd43;  9'h172: return 6'd44;
      9'h175: return 6'd45;  9'h174: return 6'd46;
      default: return NO_KEY;
    endcase
  endfunction

  logic              ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic              ps2_dat_p0, ps2_dat_p1;
  logic              fall;
  logic              bit_in;
  state_t            state, state_nx;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              par_bit;
  logic [TO_W-1:0]   to_cnt;
  logic              timeout;
  logic              rx_valid, rx_err;
  logic              ext, brk;
  logic [5:0]        key_idx;
  logic [KEYS-1:0]   flags;
  logic [39:0]       matrix;
  logic [4:0]        kbd_nx;

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous clock level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_clk_p2 <= 1'b1;
      ps2_dat_p0 <= 1'b1;
      ps2_dat_p1 <= 1'b1;
    end else begin
      ps2_clk_p0 <= bus.ps2_clk;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_clk_p2 <= ps2_clk_p1;
      ps2_dat_p0 <= bus.ps2_dat;
      ps2_dat_p1 <= ps2_dat_p0;
    end
  end

  assign fall    = ps2_clk_p2 & ~ps2_clk_p1;
  assign bit_in  = ps2_dat_p1;
  assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      to_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE)
        bit_cnt <= 3'd0;
      else if (fall && state == DATA)
        bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE || fall)
        to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT))
        to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    if (timeout) begin
      state_nx = IDLE;
      rx_err   = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    if (bit_in) rx_err = 1'b1; else state_nx = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP: begin
          state_nx = IDLE;
          if (bit_in && (^{shreg, par_bit})) rx_valid = 1'b1;
          else                               rx_err   = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fall && state == DATA)   shreg   <= {bit_in, shreg[7:1]};
    if (fall && state == PARITY) par_bit <= bit_in;
  end

  assign key_idx = key_lookup(ext, shreg);

  // Stage boundary: decoded byte updates prefixes, key flags and the strobe/err pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.scancode <= 8'h00;
      bus.strobe   <= 1'b0;
      bus.err      <= 1'b0;
      ext          <= 1'b0;
      brk          <= 1'b0;
      flags        <= '0;
    end else begin
      bus.strobe <= rx_valid;
      bus.err    <= rx_err;
      if (rx_valid) begin
        bus.scancode <= shreg;
        if (shreg == 8'hE0)
          ext <= 1'b1;
        else if (shreg == 8'hF0)
          brk <= 1'b1;
        else begin
          if (key_idx != NO_KEY) flags[key_idx] <= ~brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end else if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  always_comb begin
    matrix     = flags[39:0];
    matrix[0]  = flags[0] | flags[40] | (|flags[46:42]);
    matrix[36] = flags[36] | flags[41];
    matrix[20] = flags[20] | flags[42];
    matrix[19] = flags[19] | flags[43];
    matrix[24] = flags[24] | flags[44];
    matrix[23] = flags[23] | flags[45];
    matrix[22] = flags[22] | flags[46];
  end

  always_comb begin
    kbd_nx = 5'b11111;
    for (int i = 0; i < 8; i++)
      if (!bus.port_hi[i]) kbd_nx = kbd_nx & ~matrix[i*5 +: 5];
  end

  // Stage boundary: registered column output toward the CPU data bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.kbd_data <= 5'b11111;
    else     bus.kbd_data <= kbd_nx;
  end

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Directed and randomized bench for ps2_zx_keyboard; expected columns come from a
// held-key table and the Spectrum row layout.
module tb_ps2_zx_keyboard;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   n_strobe = 0;
  int   n_err    = 0;

  ps2_zx_keyboard_if bus ();
  ps2_zx_keyboard #(.TIMEOUT(2500)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.strobe === 1'b1) n_strobe++;
    if (bus.err === 1'b1)    n_err++;
  end

  logic       held [512];
  logic [7:0] last_code;
  logic [8:0] layout [8][5];
  logic [8:0] ex_code [7];
  int         ex_r1 [7], ex_c1 [7], ex_r2 [7], ex_c2 [7];
  logic [8:0] keys [$];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit key_down(input int r, input int c);
    bit d;
    d = held[layout[r][c]];
    for (int k = 0; k < 7; k++)
      if (held[ex_code[k]] && ((ex_r1[k] == r && ex_c1[k] == c) || (ex_r2[k] == r && ex_c2[k] == c)))
        d = 1'b1;
    return d;
  endfunction

  function automatic logic [4:0] model_kbd(input logic [7:0] ph);
    logic [4:0] res;
    res = 5'b11111;
    for (int i = 0; i < 8; i++)
      if (!ph[i])
        for (int j = 0; j < 5; j++)
          if (key_down(i, j)) res[j] = 1'b0;
    return res;
  endfunction

  task automatic ps2_bit(input logic b);
    bus.ps2_dat = b;
    wait_clk(2);
    bus.ps2_clk = 1'b0;
    wait_clk(4);
    bus.ps2_clk = 1'b1;
    wait_clk(2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    bus.ps2_dat = 1'b1;
    wait_clk(6);
  endtask

  task automatic send_good(input logic [7:0] b);
    int s0, e0;
    s0 = n_strobe;
    e0 = n_err;
    send_frame(b, 1'b0, 1'b0);
    last_code = b;
    check("scancode", 32'(bus.scancode), 32'(b));
    check("strobe_cnt", 32'(n_strobe - s0), 32'd1);
    check("err_quiet", 32'(n_err - e0), 32'd0);
  endtask

  task automatic press(input logic [8:0] code, input bit make);
    if (code[8]) send_good(8'hE0);
    if (!make)   send_good(8'hF0);
    send_good(code[7:0]);
    held[code] = make;
  endtask

  task automatic check_kbd(input string tag, input logic [7:0] ph, input logic [4:0] exp);
    bus.port_hi = ph;
    wait_clk(3);
    check(tag, 32'(bus.kbd_data), 32'(exp));
  endtask

  task automatic check_model(input string tag, input logic [7:0] ph);
    bus.port_hi = ph;
    wait_clk(3);
    check(tag, 32'(bus.kbd_data), 32'(model_kbd(ph)));
  endtask

  task automatic bad_frame(input string tag, input bit bad_par, input bit bad_stop);
    int s0, e0;
    s0 = n_strobe;
    e0 = n_err;
    send_frame(8'h1C, bad_par, bad_stop);
    check({tag, "_err"}, 32'(n_err - e0), 32'd1);
    check({tag, "_nostrobe"}, 32'(n_strobe - s0), 32'd0);
    check({tag, "_code"}, 32'(bus.scancode), 32'(last_code));
  endtask

  initial begin
    int s0, e0;
    logic [10:0] fr;
    logic [7:0]  ph;
    layout = '{'{9'h012, 9'h01A, 9'h022, 9'h021, 9'h02A},
               '{9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034},
               '{9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C},
               '{9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E},
               '{9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036},
               '{9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035},
               '{9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033},
               '{9'h029, 9'h014, 9'h03A, 9'h031, 9'h032}};
    ex_code = '{9'h059, 9'h114, 9'h066, 9'h16B, 9'h172, 9'h175, 9'h174};
    ex_r1   = '{0, 7, 0, 0, 0, 0, 0};
    ex_c1   = '{0, 1, 0, 0, 0, 0, 0};
    ex_r2   = '{0, 7, 4, 3, 4, 4, 4};
    ex_c2   = '{0, 1, 0, 4, 4, 3, 2};
    for (int i = 0; i < 512; i++) held[i] = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++) keys.push_back(layout[r][c]);
    for (int k = 0; k < 7; k++) keys.push_back(ex_code[k]);
    keys.push_back(9'h0AA); keys.push_back(9'h15A); keys.push_back(9'h11C);
    keys.push_back(9'h06B); keys.push_back(9'h0E1);
    last_code = 8'h00;

    rst = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    bus.port_hi = 8'hFF;
    wait_clk(4);
    check("rst_kbd", 32'(bus.kbd_data), 32'h1F);
    check("rst_code", 32'(bus.scancode), 32'h00);
    check("rst_strobe", 32'(bus.strobe), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;
    wait_clk(4);
    check_kbd("rst_row_all", 8'h00, 5'b11111);

    // Single key make then break
    press(9'h01C, 1'b1);
    check_kbd("t1_a_make", 8'hFD, 5'b11110);
    press(9'h01C, 1'b0);
    check_kbd("t1_a_break", 8'hFD, 5'b11111);

    // Two keys on row 0 with various row selects
    press(9'h012, 1'b1);
    press(9'h01A, 1'b1);
    check_kbd("t2_row0", 8'hFE, 5'b11100);
    check_kbd("t2_allrows", 8'h00, 5'b11100);
    check_kbd("t2_none", 8'hFF, 5'b11111);
    press(9'h012, 1'b0);
    press(9'h01A, 1'b0);

    // Extended cursor key shares CS with LShift
    press(9'h16B, 1'b1);
    check_kbd("t3_left_cs", 8'hFE, 5'b11110);
    check_kbd("t3_left_5", 8'hF7, 5'b01111);
    press(9'h012, 1'b1);
    press(9'h012, 1'b0);
    check_kbd("t3_cs_held", 8'hFE, 5'b11110);
    press(9'h16B, 1'b0);
    check_kbd("t3_released", 8'h00, 5'b11111);

    // Framing errors
    bad_frame("t4_parity", 1'b1, 1'b0);
    check_kbd("t4_par_kbd", 8'hFD, 5'b11111);
    bad_frame("t4_stop", 1'b0, 1'b1);
    check_kbd("t4_stop_kbd", 8'hFD, 5'b11111);
    send_good(8'hE0);
    bad_frame("t4_ext_clr", 1'b1, 1'b0);
    press(9'h06B, 1'b1);
    check_kbd("t4_noext_cs", 8'hFE, 5'b11111);
    check_kbd("t4_noext_5", 8'hF7, 5'b11111);
    e0 = n_err;
    ps2_bit(1'b1);
    wait_clk(4);
    check("t4_idle_start1", 32'(n_err - e0), 32'd1);

    // Timeout mid-frame, with a pending break prefix that must be dropped
    send_good(8'hF0);
    s0 = n_strobe;
    e0 = n_err;
    fr = {1'b1, ~^8'h15, 8'h15, 1'b0};
    for (int i = 0; i < 5; i++) ps2_bit(fr[i]);
    bus.ps2_dat = 1'b1;
    wait_clk(2600);
    check("t5_to_err", 32'(n_err - e0), 32'd1);
    check("t5_to_nostrobe", 32'(n_strobe - s0), 32'd0);
    press(9'h015, 1'b1);
    check_kbd("t5_q", 8'hFB, 5'b11110);
    press(9'h015, 1'b0);

    // Randomized key events against the held-key model
    for (int n = 0; n < 40; n++) begin
      press(keys[$urandom_range(0, keys.size() - 1)], 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) ph = ~(8'h01 << $urandom_range(0, 7));
      else                           ph = 8'($urandom);
      check_model("rand_kbd", ph);
    end

    // Reset mid-frame with space held
    for (int i = 0; i < 512; i++) held[i] = 1'b0;
    press(9'h0F0, 1'b1);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++) press(layout[r][c], 1'b0);
    for (int k = 0; k < 7; k++) press(ex_code[k], 1'b0);
    press(9'h029, 1'b1);
    check_kbd("t6_space", 8'h7F, 5'b11110);
    fr = {1'b1, ~^8'h1C, 8'h1C, 1'b0};
    for (int i = 0; i < 4; i++) ps2_bit(fr[i]);
    rst = 1'b1;
    wait_clk(1);
    check("t6_rst_kbd", 32'(bus.kbd_data), 32'h1F);
    check("t6_rst_code", 32'(bus.scancode), 32'h00);
    check("t6_rst_strobe", 32'(bus.strobe), 32'h0);
    check("t6_rst_err", 32'(bus.err), 32'h0);
    bus.ps2_dat = 1'b1;
    bus.ps2_clk = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    for (int i = 0; i < 512; i++) held[i] = 1'b0;
    last_code = 8'h00;
    wait_clk(3);
    check_kbd("t6_after_rst", 8'h7F, 5'b11111);
    press(9'h01C, 1'b1);
    check_kbd("t6_fresh_frame", 8'hFD, 5'b11110);
    check_model("t6_model", 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
